// File: rtl/pong_pkg.sv
// Shared pong definitions: FSM state encoding, default screen geometry and span-overlap helper.
// Pure declarations; no latency or backpressure.
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SERVE    = 3'd1,
    ST_PLAY     = 3'd2,
    ST_POINT    = 3'd3,
    ST_GAMEOVER = 3'd4
  } state_e;

  localparam int DEF_WIN_SCORE   = 7;
  localparam int DEF_SERVE_TICKS = 60;
  localparam int DEF_LPAD_EDGE   = 10;
  localparam int DEF_RPAD_EDGE   = 605;
  localparam int DEF_PAD_H       = 100;
  localparam int DEF_BALL_SZ     = 30;

  // Vertical overlap of ball and paddle; widened to 11 bits so sums cannot wrap.
  function automatic logic span_overlap(input logic [9:0]  ball_y,
                                        input logic [9:0]  pad_y,
                                        input logic [10:0] ball_sz,
                                        input logic [10:0] pad_h);
    return (({1'b0, ball_y} + ball_sz) > {1'b0, pad_y}) &&
           ({1'b0, ball_y} < ({1'b0, pad_y} + pad_h));
  endfunction

endpackage

// File: rtl/pong_serve_timer.sv
// Serve hold-off counter: load sets SERVE_TICKS-1, each tick decrements, done when it reads 0.
// Load takes effect on the next clk edge; no backpressure.
module pong_serve_timer #(
  parameter int SERVE_TICKS = 60
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic tick,
  output logic done
);

  localparam int CW = (SERVE_TICKS > 1) ? $clog2(SERVE_TICKS) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = CW'(SERVE_TICKS - 1);
    end else if (tick && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game controller: serve/play/score FSM advanced on tick; pulses registered, visible 1 clk after the tick edge.
// No backpressure. Define PONG_SPEEDUP_EN to raise speed every 4th bounce since the last serve.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int WIN_SCORE   = DEF_WIN_SCORE,
  parameter int SERVE_TICKS = DEF_SERVE_TICKS,
  parameter int LPAD_EDGE   = DEF_LPAD_EDGE,
  parameter int RPAD_EDGE   = DEF_RPAD_EDGE,
  parameter int PAD_H       = DEF_PAD_H,
  parameter int BALL_SZ     = DEF_BALL_SZ
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       start_n,
  input  logic [9:0] ball_x,
  input  logic [9:0] ball_y,
  input  logic [9:0] lpad_y,
  input  logic [9:0] rpad_y,
  output logic       ball_run,
  output logic       ball_load,
  output logic       serve_dir,
  output logic       bounce_l,
  output logic       bounce_r,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic       game_over,
  output logic       winner,
  output logic [1:0] speed,
  output logic [2:0] state
);

  localparam logic [10:0] LPAD_W  = 11'(LPAD_EDGE);
  localparam logic [10:0] RPAD_W  = 11'(RPAD_EDGE);
  localparam logic [10:0] PAD_H_W = 11'(PAD_H);
  localparam logic [10:0] BALL_W  = 11'(BALL_SZ);
  localparam logic [3:0]  WIN_W   = 4'(WIN_SCORE);

  state_e     state_q, state_d;
  logic [3:0] score_l_q, score_l_d, score_r_q, score_r_d;
  logic       serve_dir_q, serve_dir_d;
  logic       game_over_q, game_over_d;
  logic       winner_q, winner_d;
  logic       ball_load_q, ball_load_d;
  logic       bounce_l_q, bounce_l_d, bounce_r_q, bounce_r_d;
  logic       lock_l_q, lock_l_d, lock_r_q, lock_r_d;
  logic       start_prev_q, start_prev_d;

  logic press, enter_serve, serve_done;
  logic left_edge, right_edge, ovl_l, ovl_r;

  assign press      = tick && !start_n && start_prev_q;
  assign left_edge  = ({1'b0, ball_x} <= LPAD_W);
  assign right_edge = (({1'b0, ball_x} + BALL_W) >= RPAD_W);
  assign ovl_l      = span_overlap(ball_y, lpad_y, BALL_W, PAD_H_W);
  assign ovl_r      = span_overlap(ball_y, rpad_y, BALL_W, PAD_H_W);

  pong_serve_timer #(
    .SERVE_TICKS(SERVE_TICKS)
  ) u_serve_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .load (enter_serve),
    .tick (tick && (state_q == ST_SERVE)),
    .done (serve_done)
  );

  always_comb begin
    state_d      = state_q;
    score_l_d    = score_l_q;
    score_r_d    = score_r_q;
    serve_dir_d  = serve_dir_q;
    game_over_d  = game_over_q;
    winner_d     = winner_q;
    lock_l_d     = lock_l_q;
    lock_r_d     = lock_r_q;
    start_prev_d = start_prev_q;
    bounce_l_d   = 1'b0;
    bounce_r_d   = 1'b0;
    enter_serve  = 1'b0;

    if (tick) begin
      start_prev_d = start_n;
      case (state_q)
        ST_IDLE: begin
          if (press) begin
            state_d     = ST_SERVE;
            serve_dir_d = 1'b1;
            enter_serve = 1'b1;
          end
        end
        ST_SERVE: begin
          if (serve_done) state_d = ST_PLAY;
        end
        ST_PLAY: begin
          // A lockout only releases once the ball has left that side's edge region.
          if (!left_edge)  lock_l_d = 1'b0;
          if (!right_edge) lock_r_d = 1'b0;
          if (left_edge && !lock_l_q) begin
            if (ovl_l) begin
              bounce_l_d = 1'b1;
              lock_l_d   = 1'b1;
            end else begin
              score_r_d   = score_r_q + 4'd1;
              serve_dir_d = 1'b0;
              state_d     = ST_POINT;
            end
          end else if (right_edge && !lock_r_q) begin
            if (ovl_r) begin
              bounce_r_d = 1'b1;
              lock_r_d   = 1'b1;
            end else begin
              score_l_d   = score_l_q + 4'd1;
              serve_dir_d = 1'b1;
              state_d     = ST_POINT;
            end
          end
        end
        ST_POINT: begin
          if ((score_l_q == WIN_W) || (score_r_q == WIN_W)) begin
            state_d     = ST_GAMEOVER;
            game_over_d = 1'b1;
            winner_d    = (score_r_q == WIN_W);
          end else begin
            state_d     = ST_SERVE;
            enter_serve = 1'b1;
          end
        end
        ST_GAMEOVER: begin
          if (press) begin
            score_l_d   = 4'd0;
            score_r_d   = 4'd0;
            game_over_d = 1'b0;
            state_d     = ST_SERVE;
            enter_serve = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (enter_serve) begin
      lock_l_d = 1'b0;
      lock_r_d = 1'b0;
    end
    ball_load_d = enter_serve;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      score_l_q    <= 4'd0;
      score_r_q    <= 4'd0;
      serve_dir_q  <= 1'b1;
      game_over_q  <= 1'b0;
      winner_q     <= 1'b0;
      ball_load_q  <= 1'b0;
      bounce_l_q   <= 1'b0;
      bounce_r_q   <= 1'b0;
      lock_l_q     <= 1'b0;
      lock_r_q     <= 1'b0;
      start_prev_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      score_l_q    <= score_l_d;
      score_r_q    <= score_r_d;
      serve_dir_q  <= serve_dir_d;
      game_over_q  <= game_over_d;
      winner_q     <= winner_d;
      ball_load_q  <= ball_load_d;
      bounce_l_q   <= bounce_l_d;
      bounce_r_q   <= bounce_r_d;
      lock_l_q     <= lock_l_d;
      lock_r_q     <= lock_r_d;
      start_prev_q <= start_prev_d;
    end
  end

`ifdef PONG_SPEEDUP_EN
  logic [1:0] hit_cnt_q, hit_cnt_d;
  logic [1:0] speed_q, speed_d;
  logic       hit;

  assign hit = bounce_l_d | bounce_r_d;

  always_comb begin
    hit_cnt_d = hit_cnt_q;
    speed_d   = speed_q;
    if (enter_serve) begin
      hit_cnt_d = 2'd0;
      speed_d   = 2'd0;
    end else if (hit) begin
      if (hit_cnt_q == 2'd3) begin
        hit_cnt_d = 2'd0;
        if (speed_q != 2'd3) speed_d = speed_q + 2'd1;
      end else begin
        hit_cnt_d = hit_cnt_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_cnt_q <= 2'd0;
      speed_q   <= 2'd0;
    end else begin
      hit_cnt_q <= hit_cnt_d;
      speed_q   <= speed_d;
    end
  end

  assign speed = speed_q;
`else
  assign speed = 2'd0;
`endif

  assign state     = state_q;
  assign ball_run  = (state_q == ST_PLAY);
  assign ball_load = ball_load_q;
  assign serve_dir = serve_dir_q;
  assign bounce_l  = bounce_l_q;
  assign bounce_r  = bounce_r_q;
  assign score_l   = score_l_q;
  assign score_r   = score_r_q;
  assign game_over = game_over_q;
  assign winner    = winner_q;

endmodule

// File: doc/pong_game_ctrl.md
PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

Interface
REQ-001 Parameter WIN_SCORE, default 7: points needed to win; SHALL be 1..15.
REQ-002 Parameter SERVE_TICKS, default 60: ticks the ball is held before each serve; SHALL be >=1.
REQ-003 Parameter LPAD_EDGE, default 10: x of the left paddle face.
REQ-004 Parameter RPAD_EDGE, default 605: x of the right paddle face.
REQ-005 Parameter PAD_H, default 100: paddle height, in pixels.
REQ-006 Parameter BALL_SZ, default 30: ball side length, in pixels.
REQ-007 Port clk, input, 1: single system clock.
REQ-008 Port rst_n, input, 1: reset, synchronous, active-low.
REQ-009 Port tick, input, 1: game-rate enable, one clk wide.
REQ-010 Port start_n, input, 1: start button, active-low.
REQ-011 Port ball_x, input, 10: ball top-left x.
REQ-012 Port ball_y, input, 10: ball top-left y.
REQ-013 Ports lpad_y and rpad_y, input, 10 each: paddle top y.
REQ-014 Ports ball_run and ball_load, output, 1 each: ball_run enables ball motion; ball_load is a one-cycle recenter pulse.
REQ-015 Port serve_dir, output, 1: 0 = serve leftward, 1 = serve rightward.
REQ-016 Ports bounce_l and bounce_r, output, 1 each: one-cycle x-reversal pulses.
REQ-017 Ports score_l and score_r, output, 4 each: scores.
REQ-018 Ports game_over and winner, output, 1 each: winner 0 = left, 1 = right.
REQ-019 Port speed, output, 2: ball speed level.
REQ-020 Port state, output, 3: FSM state, debug only.

Function
REQ-021 All FSM transitions, counter updates and collision checks SHALL occur only on clk edges where tick=1, except as stated in REQ-022 and REQ-024.
REQ-022 A start press SHALL be the first tick on which start_n=0 after a tick on which start_n=1. A press held across a transition SHALL NOT be counted twice.
REQ-023 The FSM SHALL have the states IDLE, SERVE, PLAY, POINT and GAMEOVER.
REQ-024 Any entry into SERVE SHALL pulse ball_load for exactly one clk and SHALL load the serve counter with SERVE_TICKS-1.
REQ-025 In IDLE, a start press SHALL transition to SERVE with serve_dir=1.
REQ-026 In SERVE, each tick SHALL decrement the counter. The tick on which the counter reads 0 SHALL transition to PLAY.
REQ-027 ball_run SHALL be 1 only in PLAY.
REQ-028 In PLAY, the left check SHALL apply when ball_x <= LPAD_EDGE.
- Overlap is ball_y+BALL_SZ > lpad_y && ball_y < lpad_y+PAD_H.
- Overlap: pulse bounce_l and stay in PLAY.
- No overlap: score_r+1, serve_dir=0, go to POINT.
REQ-029 The right check SHALL mirror REQ-028, using ball_x+BALL_SZ >= RPAD_EDGE and rpad_y.
- Overlap: pulse bounce_r.
- No overlap: score_l+1, serve_dir=1, go to POINT.
REQ-030 If both edge conditions are true on the same tick, the left check SHALL take priority.
REQ-031 After a bounce on one side, further checks on that side SHALL be suppressed until the ball leaves that edge region. No double bounce is permitted.
REQ-032 All sums SHALL be evaluated at 11 bits, with no wrap-around.
REQ-033 POINT SHALL last one tick.
- If the new score equals WIN_SCORE: go to GAMEOVER, set game_over=1 and set winner.
- Otherwise: go to SERVE.
REQ-034 In GAMEOVER, scores and winner SHALL hold. A start press SHALL clear scores, game_over and speed, and then enter SERVE.

Reset
REQ-035 When rst_n=0 on a clk edge, regardless of tick or state, the block SHALL set:
- state to IDLE;
- scores, speed, counter, ball_run, ball_load, bounces, game_over and winner to 0;
- serve_dir to 1;
- bounce lockouts cleared;
- start history set to released.
REQ-036 A reset in mid-play SHALL produce no ball_load, bounce or score-change pulse on the following cycle.

Configuration
REQ-037 With PONG_SPEEDUP_EN defined:
- each 4th bounce since the last serve SHALL increment speed, saturating at 3;
- entry into SERVE SHALL clear speed.
REQ-038 Without PONG_SPEEDUP_EN, speed SHALL be constant 0 and no hit counter SHALL exist.

Structure
REQ-039 Package pong_pkg SHALL hold the state encoding (3-bit) and the default geometry constants, shared with the ball and paddle blocks.
REQ-040 The serve counter SHALL be the sub-module pong_serve_timer, with load, tick and done ports.

Verification
REQ-041 Reset, then a start press → one-clk ball_load; serve_dir=1; after exactly 60 ticks, state=PLAY and ball_run=1.
REQ-042 ball_x=5, ball_y=200, lpad_y=180 → bounce_l once; ball_x held at 5 for 3 more ticks → no further bounce.
REQ-043 ball_x=600, ball_y=0, rpad_y=300 → score_l=1, serve_dir=1, and SERVE after one POINT tick.
REQ-044 Right player scores 7 → game_over=1, winner=1; a held start produces no restart; release then press → scores 0 and SERVE.
REQ-045 With PONG_SPEEDUP_EN: 4 bounces → speed=1; 16 bounces → speed=3 (saturated); next serve → speed=0.
REQ-046 rst_n low during PLAY with score_r=3 → IDLE and all outputs at their reset values on the next clk.
